// File: rtl/dcache_plru_rep_pkg.sv
// Shared cache types: default geometry, PLRU state word and clear-FSM encoding.
package cache_types_package;

  localparam int WAYS_DEF  = 4;
  localparam int SETS_DEF  = 8;
  localparam int TAG_W_DEF = 26;

  typedef logic [WAYS_DEF-2:0] plru_state_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/dcache_plru_rep_plru_tree.sv
// Tree-PLRU combinational core: walks bits to a victim leaf (skipping
// subtrees with no available way) and computes the bits after touching a way.
module plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         bits,
  input  logic [WAYS-1:0]         avail,
  input  logic [$clog2(WAYS)-1:0] upd_way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         upd_bits
);
  localparam int LEVELS = $clog2(WAYS);

  always_comb begin
    int   prefix;
    int   node;
    int   sub;
    int   lo;
    logic dir;
    logic lo_any;
    logic hi_any;
    prefix = 0;
    node   = 0;
    sub    = 0;
    lo     = 0;
    dir    = 1'b0;
    lo_any = 1'b0;
    hi_any = 1'b0;
    // prefix is the way-index prefix of the current node; node = 2^l-1+prefix
    for (int l = 0; l < LEVELS; l++) begin
      node   = (1 << l) - 1 + prefix;
      sub    = 1 << (LEVELS - 1 - l);
      lo     = prefix * 2 * sub;
      lo_any = 1'b0;
      hi_any = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (w >= lo && w < lo + sub)           lo_any = lo_any | avail[w];
        if (w >= lo + sub && w < lo + 2 * sub) hi_any = hi_any | avail[w];
      end
      dir = bits[node];
      if (dir ? !hi_any : !lo_any) dir = ~dir;
      prefix = prefix * 2 + int'(dir);
    end
    victim = prefix[LEVELS-1:0];
  end

  always_comb begin
    int prefix;
    int node;
    prefix   = 0;
    node     = 0;
    upd_bits = bits;
    for (int l = 0; l < LEVELS; l++) begin
      prefix = int'(upd_way) >> (LEVELS - l);
      node   = (1 << l) - 1 + prefix;
      upd_bits[node] = ~upd_way[LEVELS-1-l];
    end
  end

endmodule

// File: rtl/dcache_plru_rep.sv
// Data-cache tag match and tree-PLRU replacement with a one-set-per-cycle clear.
// Optional way locking is enabled by defining DCACHE_REP_LOCK_EN.
module dcache_plru_rep
  import cache_types_package::*;
#(
  parameter int WAYS  = WAYS_DEF,
  parameter int SETS  = SETS_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      lookup_valid,
  input  logic [$clog2(SETS)-1:0]   lookup_idx,
  input  logic [TAG_W-1:0]          lookup_tag,
  input  logic [WAYS*TAG_W-1:0]     set_tags,
  input  logic [WAYS-1:0]           set_valids,
  output logic                      rsp_valid,
  output logic                      match,
  output logic [$clog2(WAYS)-1:0]   match_way,
  output logic [$clog2(WAYS)-1:0]   victim_way,
  output logic                      multi_hit,
  input  logic                      upd_valid,
  input  logic [$clog2(SETS)-1:0]   upd_idx,
  input  logic [$clog2(WAYS)-1:0]   upd_way,
  input  logic                      clr_req,
  output logic                      busy
`ifdef DCACHE_REP_LOCK_EN
  ,
  input  logic [WAYS-1:0]           lock_mask
`endif
);
  localparam int IW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);

  clr_state_e          state_reg, state_next;
  logic [IW-1:0]       clr_cnt_reg;
  logic [WAYS-2:0]     plru_mem [SETS];
  logic                clear_we;
  logic                accept;

  logic [WAYS-1:0]     avail;
  logic [WAYS-1:0]     hit_vec;
  logic [WW-1:0]       hit_way;
  logic [WW-1:0]       inv_way;
  logic                inv_any;
  logic [WAYS-2:0]     upd_bits;
  logic [WAYS-2:0]     look_bits;
  logic [WW-1:0]       walk_victim;
  logic [WW-1:0]       unused_upd_victim;
  logic [WAYS-2:0]     unused_walk_bits;

  logic                rsp_valid_reg, match_reg, multi_hit_reg;
  logic [WW-1:0]       match_way_reg, victim_way_reg;

`ifdef DCACHE_REP_LOCK_EN
  assign avail = (&lock_mask) ? {WAYS{1'b1}} : ~lock_mask;
`else
  assign avail = {WAYS{1'b1}};
`endif

  // FSM: state register, next state, outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (clr_req) state_next = ST_CLEAR;
      ST_CLEAR: if (clr_cnt_reg == IW'(SETS - 1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg == ST_CLEAR);
    clear_we = (state_reg == ST_CLEAR);
    accept   = lookup_valid && (state_reg == ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           clr_cnt_reg <= '0;
    else if (clear_we) clr_cnt_reg <= clr_cnt_reg + 1'b1;
    else               clr_cnt_reg <= '0;
  end

  // Updates arriving with clr_req still land; the clear sweep overwrites them later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) plru_mem[s] <= '0;
    end else if (clear_we) begin
      plru_mem[clr_cnt_reg] <= '0;
    end else if (upd_valid) begin
      plru_mem[upd_idx] <= upd_bits;
    end
  end

  assign look_bits = (upd_valid && !busy && (upd_idx == lookup_idx)) ? upd_bits
                                                                    : plru_mem[lookup_idx];

  plru_tree #(.WAYS(WAYS)) u_update (
    .bits     (plru_mem[upd_idx]),
    .avail    ({WAYS{1'b1}}),
    .upd_way  (upd_way),
    .victim   (unused_upd_victim),
    .upd_bits (upd_bits)
  );

  plru_tree #(.WAYS(WAYS)) u_walk (
    .bits     (look_bits),
    .avail    (avail),
    .upd_way  ({WW{1'b0}}),
    .victim   (walk_victim),
    .upd_bits (unused_walk_bits)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign hit_vec[gi] = set_valids[gi] && (set_tags[gi*TAG_W +: TAG_W] == lookup_tag);
    end
  endgenerate

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    inv_any = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WW'(w);
      if (!set_valids[w] && avail[w]) begin
        inv_way = WW'(w);
        inv_any = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid_reg  <= 1'b0;
      match_reg      <= 1'b0;
      match_way_reg  <= '0;
      victim_way_reg <= '0;
      multi_hit_reg  <= 1'b0;
    end else begin
      rsp_valid_reg <= accept;
      if (accept) begin
        match_reg      <= |hit_vec;
        match_way_reg  <= hit_way;
        victim_way_reg <= inv_any ? inv_way : walk_victim;
        multi_hit_reg  <= |(hit_vec & (hit_vec - WAYS'(1)));
      end
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign match      = match_reg;
  assign match_way  = match_way_reg;
  assign victim_way = victim_way_reg;
  assign multi_hit  = multi_hit_reg;

endmodule

// File: tb/tb_dcache_plru_rep.sv
// Scoreboard bench for dcache_plru_rep (WAYS=4, SETS=8) against a heap-indexed PLRU model.
module tb_dcache_plru_rep;
  localparam int TW = 26;
  localparam bit [TW-1:0] BASE = 26'h1234560;

  logic             clk = 1'b0;
  logic             rst;
  logic             lookup_valid;
  logic [2:0]       lookup_idx;
  logic [TW-1:0]    lookup_tag;
  logic [4*TW-1:0]  set_tags;
  logic [3:0]       set_valids;
  logic             rsp_valid, match, multi_hit, busy;
  logic [1:0]       match_way, victim_way;
  logic             upd_valid;
  logic [2:0]       upd_idx;
  logic [1:0]       upd_way;
  logic             clr_req;
  logic [3:0]       lock_mask;
  logic [3:0]       lock_next;

  always #5 clk = ~clk;

  dcache_plru_rep dut (
    .CLK(clk), .RST(rst),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_tag(lookup_tag),
    .set_tags(set_tags), .set_valids(set_valids),
    .rsp_valid(rsp_valid), .match(match), .match_way(match_way),
    .victim_way(victim_way), .multi_hit(multi_hit),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_way(upd_way),
    .clr_req(clr_req), .busy(busy)
`ifdef DCACHE_REP_LOCK_EN
    , .lock_mask(lock_mask)
`endif
  );

  typedef struct {
    bit       m;
    bit [1:0] mway;
    bit [1:0] vic;
    bit       multi;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   rsp_n  = 0;

  // Model: heap of 3 bits per set; node n has children 2n+1 / 2n+2, leaves 3..6
  bit [2:0] m_plru [8];
  bit       m_clearing;
  int       m_cnt;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic bit [3:0] avail_of(bit [3:0] lk);
`ifdef DCACHE_REP_LOCK_EN
    return (lk == 4'hF) ? 4'hF : ~lk;
`else
    return 4'hF;
`endif
  endfunction

  function automatic bit has_avail(int n, bit [3:0] av);
    int lo = n;
    int hi = n;
    bit any = 0;
    while (lo < 3) lo = 2 * lo + 1;
    while (hi < 3) hi = 2 * hi + 2;
    for (int w = lo - 3; w <= hi - 3; w++) any |= av[w];
    return any;
  endfunction

  function automatic void model_touch(int s, int w);
    int n = w + 3;
    int p;
    while (n > 0) begin
      p = (n - 1) / 2;
      m_plru[s][p] = (n == 2 * p + 1) ? 1'b1 : 1'b0;  // victim goes to the other child
      n = p;
    end
  endfunction

  function automatic int model_victim(int s, bit [3:0] vals, bit [3:0] av);
    int n = 0;
    int c;
    for (int w = 0; w < 4; w++) if (!vals[w] && av[w]) return w;
    while (n < 3) begin
      c = 2 * n + 1 + int'(m_plru[s][n]);
      if (!has_avail(c, av)) c = 2 * n + 2 - int'(m_plru[s][n]);
      n = c;
    end
    return n - 3;
  endfunction

  function automatic bit [4*TW-1:0] mk_tags(bit [TW-1:0] a, bit [TW-1:0] b,
                                           bit [TW-1:0] c, bit [TW-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic drive(bit lv, bit [2:0] li, bit [TW-1:0] lt, bit [4*TW-1:0] tg,
                       bit [3:0] vl, bit uv, bit [2:0] ui, bit [1:0] uw, bit clr);
    exp_t e;
    int   nh;
    @(posedge clk);
    #1;
    chk("busy", int'(busy), int'(m_clearing));
    lookup_valid = lv; lookup_idx = li; lookup_tag = lt; set_tags = tg; set_valids = vl;
    upd_valid = uv; upd_idx = ui; upd_way = uw; clr_req = clr; lock_mask = lock_next;
    if (!m_clearing) begin
      if (uv) model_touch(int'(ui), int'(uw));
      if (lv) begin
        nh = 0; e.m = 0; e.mway = 0; e.multi = 0;
        for (int w = 3; w >= 0; w--)
          if (vl[w] && tg[w*TW +: TW] == lt) begin nh++; e.mway = 2'(w); end
        e.m     = (nh > 0);
        e.multi = (nh > 1);
        e.vic   = 2'(model_victim(int'(li), vl, avail_of(lock_next)));
        q.push_back(e);
      end
      if (clr) begin m_clearing = 1; m_cnt = 0; end
    end else begin
      m_plru[m_cnt] = 3'b000;
      if (m_cnt == 7) m_clearing = 0;
      else m_cnt++;
    end
  endtask

  task automatic idle();
    drive(0, 3'd0, '0, '0, 4'hF, 0, 3'd0, 2'd0, 0);
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_match"}, int'(match), 0);
    chk({tag, "_match_way"}, int'(match_way), 0);
    chk({tag, "_victim_way"}, int'(victim_way), 0);
    chk({tag, "_multi_hit"}, int'(multi_hit), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got rsp_valid=1 want no response");
      end else begin
        e = q.pop_front();
        rsp_n++;
        $display("rsp %0d: match=%0b way=%0d victim=%0d multi=%0b", rsp_n,
                 match, match_way, victim_way, multi_hit);
        chk("match", int'(match), int'(e.m));
        chk("match_way", int'(match_way), int'(e.mway));
        chk("victim_way", int'(victim_way), int'(e.vic));
        chk("multi_hit", int'(multi_hit), int'(e.multi));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [4*TW-1:0] miss_tags;
    bit [4*TW-1:0] rt;
    bit [2:0]      li;
    bit [3:0]      vl;
    miss_tags = mk_tags(BASE + 26'd8, BASE + 26'd9, BASE + 26'd10, BASE + 26'd11);
    rst = 1; lookup_valid = 0; lookup_idx = 0; lookup_tag = 0; set_tags = 0;
    set_valids = 0; upd_valid = 0; upd_idx = 0; upd_way = 0; clr_req = 0;
    lock_mask = 0; lock_next = 0;
    for (int s = 0; s < 8; s++) m_plru[s] = 3'b000;
    m_clearing = 0; m_cnt = 0;

    repeat (3) @(posedge clk);
    #1 check_outputs_zero("in_reset");
    rst = 0;
    #2 check_outputs_zero("after_reset");

    // Directed scenarios
    drive(1, 3'd0, BASE, miss_tags, 4'hF, 0, 3'd0, 2'd0, 0);
    drive(0, 3'd0, BASE, miss_tags, 4'hF, 1, 3'd3, 2'd0, 0);
    drive(1, 3'd3, BASE, miss_tags, 4'hF, 0, 3'd0, 2'd0, 0);
    drive(0, 3'd0, BASE, miss_tags, 4'hF, 1, 3'd3, 2'd2, 0);
    drive(1, 3'd3, BASE, miss_tags, 4'hF, 0, 3'd0, 2'd0, 0);
    drive(1, 3'd3, BASE, miss_tags, 4'b1011, 0, 3'd0, 2'd0, 0);
    drive(1, 3'd2, BASE, mk_tags(BASE + 26'd1, BASE, BASE + 26'd2, BASE), 4'hF, 0, 3'd0, 2'd0, 0);
    drive(1, 3'd2, BASE, mk_tags(BASE, BASE, BASE, BASE), 4'b0000, 0, 3'd0, 2'd0, 0);
    drive(1, 3'd5, BASE, miss_tags, 4'hF, 1, 3'd5, 2'd0, 0);
    drive(1, 3'd4, BASE, miss_tags, 4'hF, 1, 3'd4, 2'd3, 1);  // update + clear same cycle
    drive(1, 3'd4, BASE, miss_tags, 4'hF, 1, 3'd1, 2'd1, 1);  // ignored while clearing
    repeat (8) idle();
    for (int s = 0; s < 8; s++) drive(1, 3'(s), BASE, miss_tags, 4'hF, 0, 3'd0, 2'd0, 0);

`ifdef DCACHE_REP_LOCK_EN
    lock_next = 4'b0101;
    drive(1, 3'd6, BASE, miss_tags, 4'hF, 0, 3'd0, 2'd0, 0);
    drive(1, 3'd6, BASE, miss_tags, 4'b0101, 0, 3'd0, 2'd0, 0);
    lock_next = 4'b1111;
    drive(1, 3'd6, BASE, miss_tags, 4'hF, 0, 3'd0, 2'd0, 0);
    lock_next = 4'b0000;
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      li = 3'($urandom_range(0, 7));
      vl = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
      rt = mk_tags(BASE + 26'($urandom_range(0, 5)), BASE + 26'($urandom_range(0, 5)),
                   BASE + 26'($urandom_range(0, 5)), BASE + 26'($urandom_range(0, 5)));
`ifdef DCACHE_REP_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock_next = 4'($urandom);
`endif
      drive($urandom_range(0, 3) != 0, li, BASE + 26'($urandom_range(0, 3)), rt, vl,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? li : 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom_range(0, 59) == 0);
    end
    lock_next = 4'b0000;
    repeat (10) idle();

    // Asynchronous reset in the middle of a clear
    drive(0, 3'd0, BASE, miss_tags, 4'hF, 1, 3'd2, 2'd1, 1);
    idle(); idle(); idle();
    @(posedge clk);
    #3 rst = 1;
    #1 chk("async_busy", int'(busy), 0);
    chk("async_rsp_valid", int'(rsp_valid), 0);
    for (int s = 0; s < 8; s++) m_plru[s] = 3'b000;
    m_clearing = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int s = 0; s < 8; s++) drive(1, 3'(s), BASE, miss_tags, 4'hF, 0, 3'd0, 2'd0, 0);
    repeat (3) idle();
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
